down_count_checker: RTL and testbench

DOWN_COUNT_CHECKER -- requirements
Module: down_count_checker

---
 rtl/down_count_checker_pkg.sv | 28 ++
 rtl/down_count_checker_seg7_hex.sv | 14 +
 rtl/down_count_checker.sv | 171 +++++++++++++++++
 tb/tb_down_count_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_count_checker_pkg.sv
// Shared types and constants for down_count_checker:
// checker state enumeration, active-low seven-segment table and blank pattern.
package down_count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // True for the eight legal 4-bit Johnson codes
  function automatic logic is_johnson(input logic [3:0] value);
    case (value)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/down_count_checker_seg7_hex.sv
// Hex digit to active-low seven-segment decoder (purely combinational).
module seg7_hex
  import down_count_checker_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern
  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/down_count_checker.sv
// Down-counter sequence checker: synchronises an asynchronous, possibly
// glitching 4-bit count, debounces it, and checks each accepted value
// against the expected next value of a binary or Johnson down count.
// Optional macro DOWN_CHECK_HEX_EN adds registered seven-segment displays
// of last_count (hex0) and err_count[3:0] (hex1); otherwise both are blank.
module down_count_checker
  import down_count_checker_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned JOHNSON       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       clear,
  output logic [3:0] last_count,
  output logic       locked,
  output logic       fault,
  output logic       valid_pulse,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  state_t     state;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] synced;
  logic [3:0] prev_q;
  logic [3:0] stable_q;
  logic       same;
  logic       accept;
  logic       accept_q;
  logic [3:0] accept_val_q;
  logic [3:0] expected;
  logic       match;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain on the asynchronous count input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= count_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Accept when the stability count is about to reach its ceiling
  always_comb begin
    same   = (synced == prev_q);
    accept = same && (stable_q == STABLE_MAX - 4'd1) &&
             ((state == IDLE) || (synced != last_count));
  end

  // Stability counter and one-cycle accept register (adds the +1 latency)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q       <= '0;
      stable_q     <= '0;
      accept_q     <= 1'b0;
      accept_val_q <= '0;
    end else begin
      prev_q       <= synced;
      accept_q     <= accept;
      accept_val_q <= synced;
      if (!same) begin
        stable_q <= '0;
      end else if (stable_q != STABLE_MAX) begin
        stable_q <= stable_q + 4'd1;
      end
    end
  end

  // Expected successor of last_count and match decision
  always_comb begin
    if (JOHNSON != 0) begin
      expected = {~last_count[0], last_count[3:1]};
      match    = (accept_val_q == expected) && is_johnson(accept_val_q);
    end else begin
      expected = last_count - 4'd1;
      match    = (accept_val_q == expected);
    end
  end

  // Checker FSM with registered status, pulses and error counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_count  <= '0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      valid_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      valid_pulse <= 1'b0;
      err_pulse   <= 1'b0;

      // err_count follows err_pulse by one cycle so a coincident clear yields 1
      if (clear) begin
        err_count <= err_pulse ? 8'd1 : 8'd0;
      end else if (err_pulse && (err_count != '1)) begin
        err_count <= err_count + 8'd1;
      end

      if (accept_q) begin
        last_count <= accept_val_q;
        case (state)
          IDLE: begin
            state  <= LOCKED;
            locked <= 1'b1;
            fault  <= 1'b0;
          end
          LOCKED, FAULT: begin
            if (match) begin
              valid_pulse <= 1'b1;
              state       <= LOCKED;
              locked      <= 1'b1;
              fault       <= 1'b0;
            end else begin
              err_pulse <= 1'b1;
              state     <= FAULT;
              locked    <= 1'b0;
              fault     <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
            fault  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DOWN_CHECK_HEX_EN
  logic [6:0] seg_last;
  logic [6:0] seg_err;

  seg7_hex u_hex0 (
    .value (last_count),
    .seg   (seg_last)
  );

  seg7_hex u_hex1 (
    .value (err_count[3:0]),
    .seg   (seg_err)
  );

  // Registered display outputs, blank while in reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hex0 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
    end else begin
      hex0 <= seg_last;
      hex1 <= seg_err;
    end
  end
`else
  assign hex0 = SEG_BLANK;
  assign hex1 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_down_count_checker.sv
// Randomised self-checking bench for down_count_checker: one binary and one
// Johnson instance, checked against a value-level model of the checker rules.
module tb_down_count_checker;

  localparam int S = 2;
  localparam int N = 4;
  localparam int CHK_LEN = 11;

`ifdef DOWN_CHECK_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LOCKED = 1;
  localparam int M_FAULT = 2;

  logic       clk;
  logic       reset;
  logic [3:0] cin         [2];
  logic       clear       [2];
  logic [3:0] last_count  [2];
  logic       locked      [2];
  logic       fault       [2];
  logic       valid_pulse [2];
  logic       err_pulse   [2];
  logic [7:0] err_count   [2];
  logic [6:0] hex0        [2];
  logic [6:0] hex1        [2];

  int n_tests = 0;
  int n_fail  = 0;
  int obs_valid [2] = '{0, 0};
  int obs_err   [2] = '{0, 0};

  // Reference model state
  int m_state [2];
  int m_last  [2];
  int m_errc  [2];
  int m_valid [2];
  int m_err   [2];

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int ring [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                   4'b1111, 4'b0111, 4'b0011, 4'b0001};

  down_count_checker #(.SYNC_STAGES(S), .STABLE_CYCLES(N), .JOHNSON(0)) dut_bin (
    .clock(clk), .reset(reset), .count_in(cin[0]), .clear(clear[0]),
    .last_count(last_count[0]), .locked(locked[0]), .fault(fault[0]),
    .valid_pulse(valid_pulse[0]), .err_pulse(err_pulse[0]),
    .err_count(err_count[0]), .hex0(hex0[0]), .hex1(hex1[0])
  );

  down_count_checker #(.SYNC_STAGES(S), .STABLE_CYCLES(N), .JOHNSON(1)) dut_joh (
    .clock(clk), .reset(reset), .count_in(cin[1]), .clear(clear[1]),
    .last_count(last_count[1]), .locked(locked[1]), .fault(fault[1]),
    .valid_pulse(valid_pulse[1]), .err_pulse(err_pulse[1]),
    .err_count(err_count[1]), .hex0(hex0[1]), .hex1(hex1[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (valid_pulse[d]) obs_valid[d]++;
      if (err_pulse[d])   obs_err[d]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Next value in the expected down sequence; -1 when nothing can match
  function automatic int model_next(input int d, input int last);
    if (d == 0) return (last + 15) % 16;
    for (int i = 0; i < 8; i++) if (ring[i] == last) return ring[(i + 1) % 8];
    return -1;
  endfunction

  function automatic bit valid_code(input int d, input int v);
    if (d == 0) return 1'b1;
    for (int i = 0; i < 8; i++) if (ring[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = M_IDLE;
      m_last[d]  = 0;
      m_errc[d]  = 0;
    end
  endtask

  task automatic model_accept(input int d, input int v);
    if (m_state[d] == M_IDLE) begin
      m_last[d]  = v;
      m_state[d] = M_LOCKED;
    end else if (v != m_last[d]) begin
      if (valid_code(d, v) && model_next(d, m_last[d]) == v) begin
        m_valid[d]++;
        m_state[d] = M_LOCKED;
      end else begin
        m_err[d]++;
        if (m_errc[d] < 255) m_errc[d]++;
        m_state[d] = M_FAULT;
      end
      m_last[d] = v;
    end
  endtask

  task automatic checkpoint(input int d);
    check($sformatf("last_count[%0d]", d), 32'(last_count[d]), 32'(m_last[d]));
    check($sformatf("locked[%0d]", d), 32'(locked[d]), 32'(m_state[d] == M_LOCKED));
    check($sformatf("fault[%0d]", d), 32'(fault[d]), 32'(m_state[d] == M_FAULT));
    check($sformatf("err_count[%0d]", d), 32'(err_count[d]), 32'(m_errc[d]));
    check($sformatf("valid_total[%0d]", d), 32'(obs_valid[d]), 32'(m_valid[d]));
    check($sformatf("err_total[%0d]", d), 32'(obs_err[d]), 32'(m_err[d]));
    check($sformatf("hex0[%0d]", d), 32'(hex0[d]),
          HEX_EN ? 32'(seg_ref[m_last[d]]) : 32'h7F);
    check($sformatf("hex1[%0d]", d), 32'(hex1[d]),
          HEX_EN ? 32'(seg_ref[m_errc[d] % 16]) : 32'h7F);
  endtask

  // Present v on one instance for len clock edges (called and returns at a negedge)
  task automatic hold(input int d, input int v, input int len);
    cin[d] = 4'(v);
    repeat (len) @(negedge clk);
    if (len >= N + 1) model_accept(d, v);
    if (len >= CHK_LEN) checkpoint(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_last[%0d]", d), 32'(last_count[d]), 0);
      check($sformatf("rst_locked[%0d]", d), 32'(locked[d]), 0);
      check($sformatf("rst_fault[%0d]", d), 32'(fault[d]), 0);
      check($sformatf("rst_valid[%0d]", d), 32'(valid_pulse[d]), 0);
      check($sformatf("rst_err[%0d]", d), 32'(err_pulse[d]), 0);
      check($sformatf("rst_errcnt[%0d]", d), 32'(err_count[d]), 0);
      check($sformatf("rst_hex0[%0d]", d), 32'(hex0[d]), 32'h7F);
      check($sformatf("rst_hex1[%0d]", d), 32'(hex1[d]), 32'h7F);
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_accept(d, int'(cin[d]));
      checkpoint(d);
    end
  endtask

  initial begin
    int k;
    int v;
    int len;
    int joh_seq [6] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0101};

    reset    = 1'b1;
    cin[0]   = 4'd5;
    cin[1]   = 4'd0;
    clear[0] = 1'b0;
    clear[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_err[d]   = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);

    // Binary: lock at 5 then count down through the wrap
    do_reset();
    hold(0, 4, 20); hold(0, 3, 20); hold(0, 2, 20);
    hold(0, 1, 20); hold(0, 0, 20); hold(0, 15, 20);

    // Latency from first sampling edge to valid_pulse
    cin[0] = 4'd14;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_pulse[0] && k < 40);
    check("latency", 32'(k - 1), 32'(S + N + 1));
    repeat (20 - k) @(negedge clk);
    model_accept(0, 14);
    checkpoint(0);

    // Skip in the sequence, then recovery
    hold(0, 9, 20); hold(0, 8, 20); hold(0, 6, 20); hold(0, 5, 20);

    // Short glitches, below and at the stability boundary
    hold(0, 7, 20); hold(0, 3, 2);     hold(0, 7, 20);
    hold(0, 6, N);  hold(0, 7, 20);
    hold(0, 6, N + 1); hold(0, 7, 20);

    // Johnson down sequence followed by an illegal code
    for (int i = 0; i < 6; i++) hold(1, joh_seq[i], 20);

    // Random segments on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 9) < 7 && model_next(d, m_last[d]) >= 0)
          v = model_next(d, m_last[d]);
        else
          v = int'($urandom_range(0, 15));
        if (v == int'(cin[d])) v = (v + 1) % 16;
        len = int'($urandom_range(1, 14));
        hold(d, v, len);
      end
      hold(d, (int'(cin[d]) + 5) % 16, 20);
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) hold(0, (m_last[0] + 3) % 16, 7);
    repeat (12) @(negedge clk);
    checkpoint(0);

    // Clear coincident with an err_pulse
    cin[0] = 4'((m_last[0] + 3) % 16);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err_pulse[0] && k < 40);
    check("err_pulse_seen", 32'(err_pulse[0]), 1);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    repeat (20 - k) @(negedge clk);
    model_accept(0, int'(cin[0]));
    m_errc[0] = 1;
    checkpoint(0);

    // Plain clear
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    repeat (3) @(negedge clk);
    m_errc[0] = 0;
    checkpoint(0);

    // Reset while a new value is mid-window
    cin[0] = 4'd3;
    do_reset();
    cin[0] = 4'd2;
    repeat (3) @(negedge clk);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
